// File: rtl/guvm_wb_responder_if.sv
// Bus bundle for the Wishbone responder: core-side Wishbone B3 classic
// signals, the instruction-load port and the store-log drain port.
// master = core/testbench side, slave = responder side.
interface guvm_wb_responder_if #(
  parameter int DEPTH = 8
);
  localparam int CW = $clog2(DEPTH) + 1;

  // Wishbone classic, core is the initiator
  logic [31:0]   i_wb_adr;
  logic [15:0]   i_wb_sel;
  logic          i_wb_we;
  logic [127:0]  i_wb_dat;
  logic          i_wb_cyc;
  logic          i_wb_stb;
  logic [127:0]  o_wb_dat;
  logic          o_wb_ack;
  logic          o_wb_err;

  // instruction queue load port
  logic          i_inst_valid;
  logic [31:0]   i_inst;
  logic          o_inst_ready;
  logic [CW-1:0] o_inst_count;

  // store log drain port
  logic          o_st_valid;
  logic [31:0]   o_st_adr;
  logic [127:0]  o_st_dat;
  logic [15:0]   o_st_sel;
  logic          i_st_ready;
  logic          o_st_overflow;

  modport master (
    output i_wb_adr, i_wb_sel, i_wb_we, i_wb_dat, i_wb_cyc, i_wb_stb,
    input  o_wb_dat, o_wb_ack, o_wb_err,
    output i_inst_valid, i_inst,
    input  o_inst_ready, o_inst_count,
    input  o_st_valid, o_st_adr, o_st_dat, o_st_sel, o_st_overflow,
    output i_st_ready
  );

  modport slave (
    input  i_wb_adr, i_wb_sel, i_wb_we, i_wb_dat, i_wb_cyc, i_wb_stb,
    output o_wb_dat, o_wb_ack, o_wb_err,
    input  i_inst_valid, i_inst,
    output o_inst_ready, o_inst_count,
    output o_st_valid, o_st_adr, o_st_dat, o_st_sel, o_st_overflow,
    input  i_st_ready
  );
endinterface

// File: rtl/guvm_wb_responder.sv
// Generic show-ahead FIFO used for both responder queues.
// Latency: push visible at pop side the cycle after the push edge.
// Backpressure: push_rdy low when full (push dropped); pop ignored when empty.
module guvm_wb_responder_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 32,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_vld,
  output logic          push_rdy,
  input  logic [W-1:0]  push_dat,
  output logic          pop_vld,
  input  logic          pop_rdy,
  output logic [W-1:0]  pop_dat,
  output logic [CW-1:0] count
);
  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          push_fire;
  logic          pop_fire;

  // Pointers wrap naturally (DEPTH is a power of 2); the extra count bit
  // tells full from empty when the pointers are equal.
  assign push_rdy  = (count != CW'(DEPTH));
  assign pop_vld   = (count != '0);
  assign push_fire = push_vld & push_rdy;
  assign pop_fire  = pop_rdy & pop_vld;
  assign pop_dat   = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_fire) wr_ptr <= wr_ptr + 1'b1;
      if (pop_fire)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_fire, pop_fire})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_fire) mem[wr_ptr] <= push_dat;
  end
endmodule

// Wishbone B3 classic responder for the Amber 128-bit bus: serves fetches
// from an instruction queue and logs every core write into a store log.
// Latency: ack/err WAIT_CYCLES+1 cycles after cyc&stb is sampled in IDLE.
// Backpressure: empty queue answers NOP words; full log answers err.
// Ports: i_clk, i_rst (async, active-high), bus (slave modport carrying the
//   Wishbone signals, instruction load port and store log drain port).
module guvm_wb_responder #(
  parameter int          DEPTH       = 8,
  parameter int          WAIT_CYCLES = 0,
  parameter logic [31:0] NOP_WORD    = 32'hF0801003
) (
  input logic                  i_clk,
  input logic                  i_rst,
  guvm_wb_responder_if.slave   bus
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int SW = 32 + 128 + 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_t;

  state_t        state_q;
  state_t        state_d;
  logic [3:0]    wait_q;
  logic [3:0]    wait_d;
  logic          latch_req;
  logic          enter_resp;

  logic [31:0]   adr_q;
  logic [15:0]   sel_q;
  logic          we_q;
  logic [127:0]  dat_q;
  logic          resp_err_q;
  logic [127:0]  rdat_q;
  logic          overflow_q;

  logic [31:0]   cur_adr;
  logic [15:0]   cur_sel;
  logic          cur_we;
  logic [127:0]  cur_dat;

  logic          inst_vld;
  logic [31:0]   inst_head;
  logic          inst_pop;

  logic          st_rdy;
  logic          st_push;
  logic          st_vld;
  logic [SW-1:0] st_head;
  logic          wr_err;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_d     = wait_q;
    latch_req  = 1'b0;
    enter_resp = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.i_wb_cyc && bus.i_wb_stb) begin
          latch_req = 1'b1;
          if (WAIT_CYCLES > 0) begin
            state_d = ST_WAIT;
            wait_d  = 4'(WAIT_CYCLES - 1);
          end else begin
            state_d    = ST_RESP;
            enter_resp = 1'b1;
          end
        end
      end
      ST_WAIT: begin
        // Core abandoning the cycle cancels the transfer before any queue
        // is touched.
        if (!bus.i_wb_cyc) begin
          state_d = ST_IDLE;
        end else if (wait_q == 4'd0) begin
          state_d    = ST_RESP;
          enter_resp = 1'b1;
        end else begin
          wait_d = wait_q - 4'd1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // With no wait states the response is decided in the same cycle the
  // request is sampled, so the live bus is used instead of the latch.
  always_comb begin
    cur_adr = adr_q;
    cur_sel = sel_q;
    cur_we  = we_q;
    cur_dat = dat_q;
    if (state_q == ST_IDLE) begin
      cur_adr = bus.i_wb_adr;
      cur_sel = bus.i_wb_sel;
      cur_we  = bus.i_wb_we;
      cur_dat = bus.i_wb_dat;
    end
  end

  assign inst_pop = enter_resp & ~cur_we & inst_vld;
  assign st_push  = enter_resp & cur_we & st_rdy;
  assign wr_err   = enter_resp & cur_we & ~st_rdy;

  // ------------------------------------------------- request/response regs
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      adr_q      <= '0;
      sel_q      <= '0;
      we_q       <= 1'b0;
      dat_q      <= '0;
      resp_err_q <= 1'b0;
      rdat_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (latch_req) begin
        adr_q <= bus.i_wb_adr;
        sel_q <= bus.i_wb_sel;
        we_q  <= bus.i_wb_we;
        dat_q <= bus.i_wb_dat;
      end
      if (enter_resp) begin
        resp_err_q <= wr_err;
        // Read data is only refreshed by reads; writes leave it held.
        if (!cur_we) begin
          rdat_q <= inst_vld ? {NOP_WORD, NOP_WORD, NOP_WORD, inst_head}
                             : {4{NOP_WORD}};
        end
      end
      if (wr_err) overflow_q <= 1'b1;
    end
  end

  // ack/err decode straight from the state so reset kills them at once.
  assign bus.o_wb_ack      = (state_q == ST_RESP) & ~resp_err_q;
  assign bus.o_wb_err      = (state_q == ST_RESP) & resp_err_q;
  assign bus.o_wb_dat      = rdat_q;
  assign bus.o_st_overflow = overflow_q;

  // ------------------------------------------------------------- queues
  guvm_wb_responder_fifo #(
    .DEPTH (DEPTH),
    .W     (32),
    .CW    (CW)
  ) u_inst_q (
    .clk      (i_clk),
    .rst      (i_rst),
    .push_vld (bus.i_inst_valid),
    .push_rdy (bus.o_inst_ready),
    .push_dat (bus.i_inst),
    .pop_vld  (inst_vld),
    .pop_rdy  (inst_pop),
    .pop_dat  (inst_head),
    .count    (bus.o_inst_count)
  );

  logic [CW-1:0] st_count;

  guvm_wb_responder_fifo #(
    .DEPTH (DEPTH),
    .W     (SW),
    .CW    (CW)
  ) u_store_log (
    .clk      (i_clk),
    .rst      (i_rst),
    .push_vld (st_push),
    .push_rdy (st_rdy),
    .push_dat ({cur_adr, cur_dat, cur_sel}),
    .pop_vld  (st_vld),
    .pop_rdy  (bus.i_st_ready),
    .pop_dat  (st_head),
    .count    (st_count)
  );

  // Head fields are zeroed while the log is empty so stale storage never
  // leaks onto the outputs.
  assign bus.o_st_valid = st_vld & (st_count != '0);
  assign bus.o_st_adr   = st_vld ? st_head[SW-1 -: 32]  : '0;
  assign bus.o_st_dat   = st_vld ? st_head[16 +: 128]   : '0;
  assign bus.o_st_sel   = st_vld ? st_head[15:0]        : '0;
endmodule

// File: tb/tb_guvm_wb_responder.sv
module tb_guvm_wb_responder;
  localparam int          DEPTH = 8;
  localparam logic [31:0] NOP   = 32'hF0801003;

  typedef struct packed {
    logic         ack;
    logic         err;
    logic [127:0] dat;
  } rsp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  guvm_wb_responder_if #(.DEPTH(DEPTH)) bus0 ();
  guvm_wb_responder_if #(.DEPTH(DEPTH)) bus3 ();

  guvm_wb_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(0), .NOP_WORD(NOP)) dut0 (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus0)
  );

  guvm_wb_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(3), .NOP_WORD(NOP)) dut3 (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus3)
  );

  int checks = 0;
  int errors = 0;

  rsp_t         exp_q[$];
  logic [175:0] st_q[$];
  logic [31:0]  iq0[$];
  logic [31:0]  iq3[$];
  logic [127:0] last0 = '0;
  logic [127:0] last3 = '0;

  task automatic chk(input string tag, input logic [175:0] obs, input logic [175:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit d3, input logic cyc, input logic we, input logic [31:0] adr,
                       input logic [127:0] dat, input logic [15:0] sel);
    if (d3) begin
      bus3.i_wb_cyc = cyc; bus3.i_wb_stb = cyc; bus3.i_wb_we = we;
      bus3.i_wb_adr = adr; bus3.i_wb_dat = dat; bus3.i_wb_sel = sel;
    end else begin
      bus0.i_wb_cyc = cyc; bus0.i_wb_stb = cyc; bus0.i_wb_we = we;
      bus0.i_wb_adr = adr; bus0.i_wb_dat = dat; bus0.i_wb_sel = sel;
    end
  endtask

  function automatic rsp_t rsp(input bit d3);
    rsp_t r;
    if (d3) r = {bus3.o_wb_ack, bus3.o_wb_err, bus3.o_wb_dat};
    else    r = {bus0.o_wb_ack, bus0.o_wb_err, bus0.o_wb_dat};
    return r;
  endfunction

  // One bus transfer; lat stays 0 if no ack/err shows up within the bound.
  task automatic xfer(input bit d3, input logic we, input logic [31:0] adr, input logic [127:0] dat,
                      input logic [15:0] sel, input int drop_at, output int lat, output rsp_t r);
    lat = 0;
    drive(d3, 1'b1, we, adr, dat, sel);
    r = rsp(d3);
    for (int i = 1; i <= 12; i++) begin
      step();
      if (i == drop_at) drive(d3, 1'b0, 1'b0, '0, '0, '0);
      r = rsp(d3);
      if (r.ack || r.err) begin
        lat = i;
        break;
      end
    end
    drive(d3, 1'b0, 1'b0, '0, '0, '0);
    step();
  endtask

  task automatic score(input string tag, input rsp_t r);
    rsp_t e;
    if (exp_q.size() == 0) begin
      chk({tag, "_noexp"}, 176'(r), '1);
    end else begin
      e = exp_q.pop_front();
      chk(tag, 176'(r), 176'(e));
    end
  endtask

  task automatic load(input bit d3, input logic [31:0] w);
    if (d3) begin
      bus3.i_inst_valid = 1'b1; bus3.i_inst = w;
      if (iq3.size() < DEPTH) iq3.push_back(w);
    end else begin
      bus0.i_inst_valid = 1'b1; bus0.i_inst = w;
      if (iq0.size() < DEPTH) iq0.push_back(w);
    end
    step();
    bus0.i_inst_valid = 1'b0;
    bus3.i_inst_valid = 1'b0;
  endtask

  function automatic rsp_t read_exp(input bit d3);
    rsp_t e;
    e.ack = 1'b1;
    e.err = 1'b0;
    if (d3) begin
      e.dat = (iq3.size() != 0) ? {NOP, NOP, NOP, iq3.pop_front()} : {4{NOP}};
      last3 = e.dat;
    end else begin
      e.dat = (iq0.size() != 0) ? {NOP, NOP, NOP, iq0.pop_front()} : {4{NOP}};
      last0 = e.dat;
    end
    return e;
  endfunction

  task automatic do_read(input bit d3, input string tag, input int exp_lat);
    rsp_t r;
    int   lat;
    exp_q.push_back(read_exp(d3));
    xfer(d3, 1'b0, 32'h0, '0, 16'hFFFF, 0, lat, r);
    score(tag, r);
    chk({tag, "_lat"}, 176'(lat), 176'(exp_lat));
  endtask

  task automatic do_write(input string tag, input logic [31:0] adr, input logic [127:0] dat,
                          input logic [15:0] sel, input logic exp_err);
    rsp_t r;
    rsp_t e;
    int   lat;
    e.ack = ~exp_err;
    e.err = exp_err;
    e.dat = last0;
    exp_q.push_back(e);
    if (!exp_err) st_q.push_back({adr, dat, sel});
    xfer(1'b0, 1'b1, adr, dat, sel, 0, lat, r);
    score(tag, r);
  endtask

  task automatic drain(input string tag, input int n_exp);
    int n = 0;
    bus0.i_st_ready = 1'b1;
    for (int i = 0; i < DEPTH + 4; i++) begin
      if (!bus0.o_st_valid) break;
      chk(tag, {bus0.o_st_adr, bus0.o_st_dat, bus0.o_st_sel}, (st_q.size() != 0) ? st_q.pop_front() : '1);
      n++;
      step();
    end
    bus0.i_st_ready = 1'b0;
    chk({tag, "_n"}, 176'(n), 176'(n_exp));
  endtask

  initial begin
    rsp_t r;
    int   lat;

    drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
    drive(1'b1, 1'b0, 1'b0, '0, '0, '0);
    bus0.i_inst_valid = 1'b0; bus0.i_inst = '0; bus0.i_st_ready = 1'b0;
    bus3.i_inst_valid = 1'b0; bus3.i_inst = '0; bus3.i_st_ready = 1'b0;

    // reset state
    repeat (3) step();
    chk("rst_ctl", 176'({bus0.o_wb_ack, bus0.o_wb_err, bus0.o_st_valid, bus0.o_st_overflow, bus0.o_inst_count}), '0);
    chk("rst_dat", 176'(bus0.o_wb_dat), '0);
    chk("rst_rdy", 176'(bus0.o_inst_ready), 176'(1));
    rst = 1'b0;
    step();

    // 1: two fetches, zero wait states
    load(1'b0, 32'hE3A01005);
    load(1'b0, 32'hE2811001);
    chk("t1_count", 176'(bus0.o_inst_count), 176'(2));
    do_read(1'b0, "t1_rd0", 1);
    do_read(1'b0, "t1_rd1", 1);

    // 2: empty queue answers NOP words, no pop
    do_read(1'b0, "t2_empty", 1);
    chk("t2_count", 176'(bus0.o_inst_count), '0);

    // 3: single write lands in the store log, then drains
    do_write("t3_wr", 32'h100, 128'hDEADBEEF, 16'h000F, 1'b0);
    chk("t3_valid", 176'(bus0.o_st_valid), 176'(1));
    drain("t3_head", 1);
    chk("t3_empty", 176'(bus0.o_st_valid), '0);

    // 4: DEPTH+1 writes with the scoreboard stalled
    for (int i = 0; i <= DEPTH; i++) begin
      if (i == DEPTH) chk("t4_ovf_before", 176'(bus0.o_st_overflow), '0);
      do_write("t4_wr", 32'h200 + 32'(i * 16), {4{32'h1000 + 32'(i)}}, 16'hFFFF, (i == DEPTH));
    end
    chk("t4_ovf", 176'(bus0.o_st_overflow), 176'(1));
    drain("t4_log", DEPTH);
    chk("t4_ovf_sticky", 176'(bus0.o_st_overflow), 176'(1));

    // 5: three wait states, then an abandoned cycle
    load(1'b1, 32'hE1A00000);
    do_read(1'b1, "t5_rd", 4);
    load(1'b1, 32'hE3A0200A);
    exp_q.push_back('{ack: 1'b0, err: 1'b0, dat: last3});
    xfer(1'b1, 1'b0, 32'h0, '0, 16'hFFFF, 2, lat, r);
    score("t5_abort", r);
    chk("t5_abort_count", 176'(bus3.o_inst_count), 176'(1));
    do_read(1'b1, "t5_rd_after", 4);

    // 6a: pop with a push offered while full -> push refused, count drops
    for (int i = 0; i < DEPTH; i++) load(1'b0, 32'hA000_0000 + 32'(i));
    chk("t6_full_count", 176'(bus0.o_inst_count), 176'(DEPTH));
    chk("t6_full_rdy", 176'(bus0.o_inst_ready), '0);
    exp_q.push_back(read_exp(1'b0));
    drive(1'b0, 1'b1, 1'b0, '0, '0, 16'hFFFF);
    bus0.i_inst_valid = 1'b1; bus0.i_inst = 32'hBAD0BAD0;
    step();
    bus0.i_inst_valid = 1'b0;
    r = rsp(1'b0);
    drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
    score("t6_full_rd", r);
    chk("t6_full_pp_count", 176'(bus0.o_inst_count), 176'(DEPTH - 1));
    step();
    for (int i = 1; i < DEPTH; i++) do_read(1'b0, "t6_drain_rd", 1);
    chk("t6_drained", 176'(bus0.o_inst_count), '0);

    // 6b: push alongside a read of an empty queue -> no pop, count 1
    exp_q.push_back(read_exp(1'b0));
    drive(1'b0, 1'b1, 1'b0, '0, '0, 16'hFFFF);
    bus0.i_inst_valid = 1'b1; bus0.i_inst = 32'hE12FFF1E;
    step();
    bus0.i_inst_valid = 1'b0;
    r = rsp(1'b0);
    drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
    iq0.push_back(32'hE12FFF1E);
    score("t6_empty_rd", r);
    chk("t6_empty_pp_count", 176'(bus0.o_inst_count), 176'(1));
    step();
    do_read(1'b0, "t6_wrap_rd", 1);

    // 6c: reset asserted while the wait-state responder is in WAIT
    load(1'b1, 32'hE3A03001);
    load(1'b0, 32'hE3A04002);
    drive(1'b1, 1'b1, 1'b0, '0, '0, 16'hFFFF);
    step();
    step();
    rst = 1'b1;
    #1;
    chk("t6_rst_ackerr", 176'({bus3.o_wb_ack, bus3.o_wb_err}), '0);
    chk("t6_rst_counts", 176'({bus3.o_inst_count, bus0.o_inst_count}), '0);
    chk("t6_rst_ovf", 176'({bus0.o_st_overflow, bus0.o_st_valid}), '0);
    drive(1'b1, 1'b0, 1'b0, '0, '0, '0);
    iq0.delete();
    iq3.delete();
    st_q.delete();
    step();
    rst = 1'b0;
    step();
    chk("t6_post_rst_ack", 176'(bus3.o_wb_ack), '0);
    do_read(1'b1, "t6_post_rst_rd", 4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
